// File: rtl/seg_disp_ctrl.sv
// seg_disp_ctrl: handshake-fed double-dabble BCD converter driving active-low seven-segment digits
module seg_disp_ctrl #(
  parameter int DATA_W = 20,
  parameter int DIGITS = 6,
  parameter int LZS    = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic [DATA_W-1:0]     in_data,
  output logic                  in_ready,
  input  logic                  enable,
  output logic [DIGITS*8-1:0]   seg,
  output logic                  done,
  output logic                  overflow
);
  localparam int BW = DIGITS * 4;
  localparam int CW = $clog2(DATA_W + 1);
  typedef enum logic [1:0] {IDLE, CONV, LOAD} state_t;
  state_t state, state_nx;
  logic [DATA_W-1:0] sh;
  logic [BW-1:0] bcd, adj, held;
  logic [CW-1:0] cnt;
  logic sticky, load, lead, blank;
  logic [3:0] d;
  logic [DIGITS*8-1:0] seg_enc;
  function automatic logic [7:0] enc(input logic [3:0] v);
    case (v)
      4'd0: enc = 8'hC0;
      4'd1: enc = 8'hF9;
      4'd2: enc = 8'hA4;
      4'd3: enc = 8'hB0;
      4'd4: enc = 8'h99;
      4'd5: enc = 8'h92;
      4'd6: enc = 8'h82;
      4'd7: enc = 8'hF8;
      4'd8: enc = 8'h80;
      4'd9: enc = 8'h90;
      default: enc = 8'hFF;
    endcase
  endfunction
  assign in_ready = (state == IDLE);
  always_comb begin
    state_nx = (state == IDLE && in_valid) ? CONV :
               (state == CONV && cnt == CW'(1)) ? LOAD :
               (state == LOAD) ? IDLE : state;
  end
  always_ff @(posedge clk) state <= rst ? IDLE : state_nx;
  always_comb begin
    adj = bcd;
    for (int i = 0; i < DIGITS; i++)
      adj[4*i +: 4] = (bcd[4*i +: 4] >= 4'd5) ? bcd[4*i +: 4] + 4'd3 : bcd[4*i +: 4];
  end
  // Walk from the top digit down; a digit is blanked while only zeros have been seen above it
  always_comb begin
    seg_enc = '1;
    lead = 1'b1;
    blank = 1'b0;
    d = '0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      d = held[4*i +: 4];
      blank = (LZS != 0) && lead && (d == 4'd0) && (i != 0);
      lead = lead && (d == 4'd0);
      seg_enc[8*i +: 8] = overflow ? 8'hBF : blank ? 8'hFF : enc(d);
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      sh <= '0;
      bcd <= '0;
      cnt <= '0;
      sticky <= 1'b0;
      held <= '0;
      overflow <= 1'b0;
      load <= 1'b0;
      done <= 1'b0;
      seg <= '1;
    end else begin
      load <= (state == LOAD);
      done <= load;
      seg <= enable ? seg_enc : '1;
      if (state == IDLE && in_valid) begin
        sh <= in_data;
        bcd <= '0;
        sticky <= 1'b0;
        cnt <= CW'(DATA_W);
      end
      if (state == CONV) begin
        {bcd, sh} <= {adj[BW-2:0], sh, 1'b0};
        sticky <= sticky | adj[BW-1];
        cnt <= cnt - CW'(1);
      end
      if (state == LOAD) begin
        held <= bcd;
        overflow <= sticky;
      end
    end
  end
endmodule

// File: tb/tb_seg_disp_ctrl.sv
// tb_seg_disp_ctrl: randomized and directed checks of seg_disp_ctrl against a decimal-arithmetic model
module tb_seg_disp_ctrl;
  logic clk = 0, rst = 1, in_valid = 0, enable = 1;
  logic [19:0] in_data = '0;
  logic in_ready, done, overflow, in_ready0, done0, overflow0;
  logic [47:0] seg, seg0;
  int checks = 0, failures = 0;
  logic [7:0] tbl [0:9] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};

  seg_disp_ctrl #(.DATA_W(20), .DIGITS(6), .LZS(1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .enable(enable), .seg(seg), .done(done), .overflow(overflow));
  seg_disp_ctrl #(.DATA_W(20), .DIGITS(6), .LZS(0)) dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready0),
    .enable(enable), .seg(seg0), .done(done0), .overflow(overflow0));

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [47:0] model(input int unsigned v, input logic en, input bit lzs);
    logic [47:0] r;
    int unsigned p;
    p = 1;
    for (int i = 0; i < 6; i++) begin
      r[8*i +: 8] = !en ? 8'hFF : (v >= 1000000) ? 8'hBF :
                    (lzs && i > 0 && v < p) ? 8'hFF : tbl[(v / p) % 10];
      p = p * 10;
    end
    return r;
  endfunction

  task automatic run_value(input logic [19:0] v);
    int n;
    logic [47:0] e1, e0;
    in_data = v;
    in_valid = 1;
    tick();
    in_valid = 0;
    in_data = 20'($urandom);
    n = 0;
    while (!in_ready && n < 100) begin
      checks++;
      if (done !== 1'b0) begin failures++; $display("FAIL done_early v=%0d got=%b want=0", v, done); end
      tick();
      n++;
    end
    checks++;
    if (n !== 21) begin failures++; $display("FAIL ready_low_cycles v=%0d got=%0d want=21", v, n); end
    tick();
    e1 = model(v, enable, 1);
    e0 = model(v, enable, 0);
    checks++;
    if (done !== 1'b1 || done0 !== 1'b1) begin failures++; $display("FAIL done_pulse v=%0d got=%b%b want=11", v, done, done0); end
    checks++;
    if (seg !== e1) begin failures++; $display("FAIL seg_lzs v=%0d got=%h want=%h", v, seg, e1); end
    checks++;
    if (seg0 !== e0) begin failures++; $display("FAIL seg_nolzs v=%0d got=%h want=%h", v, seg0, e0); end
    checks++;
    if (overflow !== (v >= 1000000)) begin failures++; $display("FAIL overflow v=%0d got=%b want=%b", v, overflow, v >= 1000000); end
    tick();
    checks++;
    if (done !== 1'b0) begin failures++; $display("FAIL done_width v=%0d got=%b want=0", v, done); end
  endtask

  task automatic test_reset();
    rst = 1;
    tick();
    tick();
    checks++;
    if (seg !== 48'hFFFF_FFFF_FFFF) begin failures++; $display("FAIL reset_seg got=%h want=ffffffffffff", seg); end
    checks++;
    if (done !== 0 || overflow !== 0) begin failures++; $display("FAIL reset_flags got=%b%b want=00", done, overflow); end
    checks++;
    if (in_ready !== 1) begin failures++; $display("FAIL reset_ready got=%b want=1", in_ready); end
    rst = 0;
  endtask

  task automatic test_directed();
    enable = 1;
    run_value(20'd1234);
    run_value(20'd0);
    run_value(20'd999999);
    run_value(20'd1000000);
    run_value(20'd5);
  endtask

  task automatic test_random();
    for (int k = 0; k < 10; k++) begin
      enable = ($urandom_range(0, 3) != 0);
      run_value(20'($urandom_range(0, 1048575)));
    end
    enable = 1;
  endtask

  task automatic test_enable();
    logic [47:0] e;
    enable = 0;
    run_value(20'd42);
    enable = 1;
    tick();
    e = model(42, 1, 1);
    checks++;
    if (seg !== e) begin failures++; $display("FAIL enable_rise got=%h want=%h", seg, e); end
    checks++;
    if (done !== 0) begin failures++; $display("FAIL enable_rise_done got=%b want=0", done); end
  endtask

  task automatic test_back_to_back();
    int dc, n;
    logic [47:0] e;
    dc = 0;
    in_data = 20'd7;
    in_valid = 1;
    tick();
    in_data = 20'd8;
    for (int t = 1; t <= 44; t++) begin
      tick();
      dc += int'(done);
      if (t == 21) begin
        checks++;
        if (in_ready !== 1) begin failures++; $display("FAIL b2b_ready_back got=%b want=1", in_ready); end
      end
      if (t == 22) begin
        e = model(7, 1, 1);
        checks++;
        if (seg !== e) begin failures++; $display("FAIL b2b_first got=%h want=%h", seg, e); end
      end
      if (t == 44) begin
        e = model(8, 1, 1);
        checks++;
        if (seg !== e) begin failures++; $display("FAIL b2b_second got=%h want=%h", seg, e); end
      end
    end
    checks++;
    if (dc !== 2) begin failures++; $display("FAIL b2b_done_count got=%0d want=2", dc); end
    in_valid = 0;
    n = 0;
    while (!in_ready && n < 40) begin tick(); n++; end
    checks++;
    if (!in_ready) begin failures++; $display("FAIL b2b_drain got=%b want=1", in_ready); end
    tick();
    tick();
  endtask

  task automatic test_reset_abort();
    int dc;
    run_value(20'd1000000);
    in_data = 20'd555;
    in_valid = 1;
    tick();
    in_valid = 0;
    repeat (9) tick();
    rst = 1;
    tick();
    checks++;
    if (seg !== 48'hFFFF_FFFF_FFFF) begin failures++; $display("FAIL abort_seg got=%h want=ffffffffffff", seg); end
    checks++;
    if (in_ready !== 1 || overflow !== 0 || done !== 0) begin
      failures++; $display("FAIL abort_flags got=%b%b%b want=100", in_ready, overflow, done);
    end
    rst = 0;
    dc = 0;
    repeat (30) begin tick(); dc += int'(done); end
    checks++;
    if (dc !== 0) begin failures++; $display("FAIL abort_no_done got=%0d want=0", dc); end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_enable();
    test_back_to_back();
    test_reset_abort();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/seg_disp_ctrl.md
Name: seg_disp_ctrl

Overview:
- Parametrised, clocked seven-segment display controller.
- Accepts a binary value over a valid/ready handshake and converts it to BCD with an iterative shift-add-3 (double-dabble) engine, one bit per cycle.
- Drives DIGITS active-low segment bytes, with optional leading-zero suppression, overflow dashes and a registered display enable.
- Sits between the ALU/result logic and the board's seven-segment pins, and replaces the purely combinational decimal display path.

Parameters:
- DATA_W, 20: width of in_data; legal range 4..32.
- DIGITS, 6: number of seven-segment digits driven; legal range 1..8.
- LZS, 1: 1 = blank leading zeros; 0 = show all digits.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  in_data is offered this cycle.
- in_data  input  DATA_W  unsigned binary value to display.
- in_ready  output  1  controller is idle and will accept in_data this cycle.
- enable  input  1  1 = display on; 0 = all segments dark.
- seg  output  DIGITS*8  segment bytes; digit 0 (rightmost) at bits [7:0]; each byte is {dp,g,f,e,d,c,b,a}, active-low.
- done  output  1  one-cycle pulse when seg first shows a new result.
- overflow  output  1  the last converted value was ≥ 10^DIGITS; held until the next result.

Behaviour:
- Reset (rst high at a rising edge):
  - state = IDLE; seg = all 8'hFF; done = 0; overflow = 0.
  - Held digit registers are cleared.
  - An in-flight conversion is discarded, and no done pulse follows.
- in_ready = (state == IDLE). It is combinational from state, so it is 1 in the first cycle after reset.
- States:
  - IDLE: a transfer occurs at a rising edge with in_valid & in_ready. in_data is latched into the shift register, the BCD accumulator (DIGITS*4 bits) and the overflow sticky bit are cleared, the bit counter is set to DATA_W, and the state goes to CONV. With in_valid low, stay in IDLE.
  - CONV: each cycle, every BCD nibble ≥ 5 gets +3, then {bcd, shift} shifts left by 1. Any 1 shifted out of the top BCD nibble sets the sticky overflow bit. The counter decrements, and when it reaches 0 the state goes to LOAD. This takes exactly DATA_W cycles. in_ready = 0, and in_valid is ignored (no queueing).
  - LOAD (1 cycle): copy the BCD result into the held-digit registers, copy the sticky bit into the overflow output, assert an internal load flag, and return to IDLE.
- Output stage, registered every cycle:
  - seg_next = enable ? encode(held digits) : all 8'hFF.
  - enable therefore takes effect at the next edge, and conversion proceeds regardless of enable.
  - done is registered from the load flag, so it is high in exactly the cycle seg first reflects the new digits.
- Latency: with acceptance at edge E, seg and done update at edge E + DATA_W + 2. Back-to-back throughput is one value per DATA_W + 2 cycles.
- Digit encoding (active-low, dp always 1): 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8, 8=80, 9=90, blank=FF, dash=BF.
- Leading-zero suppression (LZS = 1): every zero digit to the left of the most significant nonzero digit shows FF. Digit 0 is never suppressed, so value 0 shows "0".
- Overflow: when overflow = 1 and enable = 1, all DIGITS bytes show BF, regardless of LZS.
- Simultaneous events:
  - rst wins over everything.
  - An enable change in the same cycle as LOAD: the next seg uses the new enable value with the new digits.

Test Plan:
- Reset, then in_data=1234 with in_valid for 1 cycle, enable=1, LZS=1, DIGITS=6 → in_ready low for 21 cycles. At E+22, seg = FF_FF_F9_A4_B0_99 (digit5..digit0), done=1 for one cycle, overflow=0.
- in_data=0 → seg = FF_FF_FF_FF_FF_C0. With LZS=0 → seg = C0_C0_C0_C0_C0_C0.
- in_data=999999 → all six bytes 90, overflow=0. Then in_data=1000000 → overflow=1, all six bytes BF.
- enable=0 while converting 42 → seg stays all FF and done still pulses. Raise enable → next edge seg = FF_FF_FF_FF_99_A4.
- in_valid held high continuously with values 7 then 8 → second value accepted only when in_ready returns (22 cycles later); values offered during CONV/LOAD are dropped; done pulses once per accepted value.
- rst asserted at cycle 10 of a conversion → next edge: seg all FF, in_ready=1, overflow=0, and no done pulse for the aborted value.
